// File: rtl/clock_divider_prog_if.sv
// Purpose : control/status bundle for clock_divider_prog (enable, ratio load handshake, divided outputs).
// Latency : pure wiring, no storage.
// Backpressure: div_load is only taken while div_ready is high; the master must hold div_in/div_load until then.
//
// Signals:
//   en        master->slave  run enable
//   div_in    master->slave  requested divide ratio
//   div_load  master->slave  div_in valid
//   div_ready slave->master  no ratio update pending
//   div_cur   slave->master  ratio currently in effect
//   clk_out   slave->master  divided clock
//   tick      slave->master  one-cycle pulse on each clk_out rising transition
interface clock_divider_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_ready;
  logic [WIDTH-1:0] div_cur;
  logic             clk_out;
  logic             tick;

  modport master (
    output en, div_in, div_load,
    input  div_ready, div_cur, clk_out, tick
  );

  modport slave (
    input  en, div_in, div_load,
    output div_ready, div_cur, clk_out, tick
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Purpose : programmable integer clock divider, clk_out period = N clk_in cycles, ceil(N/2) high / floor(N/2) low.
// Latency : clk_out/tick rise one cycle after en is first sampled high; new ratios take effect at the next period boundary.
// Backpressure: one pending ratio at a time; div_ready low while it waits, further div_load pulses are dropped.
//
// Ports:
//   clk_in  sole clock (rising edge; one falling-edge flop when CLK_DIV_ODD_DUTY_EN is defined)
//   rst     synchronous active-high reset
//   bus     clock_divider_prog_if.slave (en, div_in, div_load, div_ready, div_cur, clk_out, tick)
//
// Optional build macro CLK_DIV_ODD_DUTY_EN: for odd N, clk_out is trimmed by half a cycle using a
// falling-edge copy of the high flag, giving exactly 50% duty. Undefined: rising-edge logic only.
module clock_divider_prog #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 2
) (
  input logic                 clk_in,
  input logic                 rst,
  clock_divider_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_vld;
  logic             high_q, high_nxt;
  logic             tick_q, tick_nxt;
  logic             apply_pend;
  logic [WIDTH:0]   hi_len;
  logic [WIDTH-1:0] hi_last;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] div_clamped;

  // High phase covers counts 0 .. ceil(N/2)-1; one extra bit so N = 2^WIDTH-1 does not overflow.
  assign hi_len      = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
  assign hi_last     = hi_len[WIDTH-1:0] - ONE;
  assign last_cnt    = div_q - ONE;
  assign div_clamped = (bus.div_in < TWO) ? TWO : bus.div_in;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    apply_pend = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt    = '0;
        // Nothing is running, so a pending ratio can be adopted straight away.
        apply_pend = pend_vld;
        if (bus.en) begin
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        cnt_nxt = cnt + ONE;
        if (cnt == hi_last) begin
          state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt == last_cnt) begin
          // Period boundary: en is only honoured here so phases are never truncated.
          cnt_nxt    = '0;
          state_nxt  = bus.en ? S_HIGH : S_IDLE;
          apply_pend = pend_vld;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    high_nxt = (state_nxt == S_HIGH);
    // Every entry into HIGH comes from IDLE or LOW, so this is exactly the clk_out rising cycle.
    tick_nxt = (state_nxt == S_HIGH) && (state != S_HIGH);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      high_q   <= 1'b0;
      tick_q   <= 1'b0;
      div_q    <= WIDTH'(DIV_RESET);
      pend_q   <= '0;
      pend_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      high_q <= high_nxt;
      tick_q <= tick_nxt;
      // apply and accept are mutually exclusive: accept needs pend_vld low, apply needs it high.
      // A load accepted on a boundary edge is therefore held for the following boundary.
      if (apply_pend) begin
        div_q    <= pend_q;
        pend_vld <= 1'b0;
      end else if (bus.div_load && !pend_vld) begin
        pend_q   <= div_clamped;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic high_neg;

  // Half-cycle delayed high flag; ANDing it in trims the leading half cycle of the high phase.
  always_ff @(negedge clk_in) begin
    if (rst) begin
      high_neg <= 1'b0;
    end else begin
      high_neg <= high_q;
    end
  end

  assign bus.clk_out = div_q[0] ? (high_q & high_neg) : high_q;
`else
  assign bus.clk_out = high_q;
`endif

  assign bus.tick      = tick_q;
  assign bus.div_ready = !pend_vld;
  assign bus.div_cur   = div_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Purpose : directed checks of clock_divider_prog; expected clk_out phases are queued by the stimulus and
//           compared by an edge-driven monitor, status outputs are compared inline.
// Latency : phase lengths measured in half clk_in cycles between clk_out edges.
// Backpressure: n/a (bench).
module tb_clock_divider_prog;
  localparam int  WIDTH = 8;
  localparam real HALF  = 5.0;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  clock_divider_prog_if #(.WIDTH(WIDTH)) bus ();

  clock_divider_prog #(
    .WIDTH    (WIDTH),
    .DIV_RESET(2)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // One completed clk_out phase: level, length in half cycles (-1 = any), div_cur just after it ends (-1 = any).
  typedef struct {
    logic lvl;
    int   halves;
    int   divc;
  } phase_t;

  phase_t  exp_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;
  realtime last_t = 0.0;
  logic    tick_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $realtime);
    end
  endtask

  task automatic push(input logic lvl, input int halves, input int divc);
    phase_t p;
    p.lvl    = lvl;
    p.halves = halves;
    p.divc   = divc;
    exp_q.push_back(p);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Phase monitor.
  realtime now;
  int      meas;
  logic    lvl_end;
  logic    rising;
  phase_t  e;
  always @(bus.clk_out) begin
    now     = $realtime;
    rising  = bus.clk_out;
    lvl_end = ~bus.clk_out;
    meas    = int'((now - last_t) / HALF);
    last_t  = now;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL phase_unexpected: level %0d of %0d halves ended, none expected", lvl_end, meas);
      end else begin
        e = exp_q.pop_front();
        check("phase_level", int'(lvl_end), int'(e.lvl));
        if (e.halves >= 0) check("phase_halves", meas, e.halves);
        #1;
        if (rising) check("tick_at_rise", int'(bus.tick), 1);
        if (e.divc >= 0) check("div_cur_at_fall", int'(bus.div_cur), e.divc);
      end
    end
  end

  // tick must never be high on two consecutive cycles.
  always @(negedge clk_in) begin
    if (mon_en && bus.tick) begin
      check("tick_not_consecutive", int'(tick_prev), 0);
    end
    tick_prev = bus.tick;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en       = 1'b0;
    bus.div_in   = '0;
    bus.div_load = 1'b0;
    rst          = 1'b1;

    // Reset state.
    cyc(3);
    check("rst_clk_out",   int'(bus.clk_out),   0);
    check("rst_tick",      int'(bus.tick),      0);
    check("rst_div_cur",   int'(bus.div_cur),   2);
    check("rst_div_ready", int'(bus.div_ready), 1);
    mon_en = 1'b1;
    last_t = $realtime;

    // N=2 from reset: four 1-high/1-low periods, then stop.
    push(1'b0, -1, -1);
    push(1'b1, 2, 2); push(1'b0, 2, -1);
    push(1'b1, 2, 2); push(1'b0, 2, -1);
    push(1'b1, 2, 2); push(1'b0, 2, -1);
    push(1'b1, 2, 2);
    rst    = 1'b0;
    bus.en = 1'b1;
    cyc(1);
    check("start_clk_out", int'(bus.clk_out), 1);
    check("start_tick",    int'(bus.tick),    1);
    check("start_div_cur", int'(bus.div_cur), 2);
    cyc(1);
    check("n2_low_clk_out", int'(bus.clk_out), 0);
    check("n2_low_tick",    int'(bus.tick),    0);
    cyc(5);
    bus.en = 1'b0;

    // Load 4 while idle, run, then load 6 mid-period.
    cyc(3);
    push(1'b0, -1, -1);
    push(1'b1, 4, 4); push(1'b0, 4, -1);
    push(1'b1, 4, 4); push(1'b0, 4, -1);
    push(1'b1, 6, 6); push(1'b0, 6, -1);
    push(1'b1, 6, 6);
    bus.div_in   = 8'd4;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    check("idle_load_ready_low", int'(bus.div_ready), 0);
    cyc(1);
    check("idle_load_div_cur", int'(bus.div_cur),   4);
    check("idle_load_ready",   int'(bus.div_ready), 1);
    bus.en = 1'b1;
    cyc(6);
    bus.div_in   = 8'd6;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    check("mid_load_ready_low", int'(bus.div_ready), 0);
    check("mid_load_div_cur",   int'(bus.div_cur),   4);
    cyc(2);
    check("boundary_div_cur", int'(bus.div_cur),   6);
    check("boundary_ready",   int'(bus.div_ready), 1);
    cyc(9);
    bus.en = 1'b0;

    // N=5: odd ratio.
    cyc(4);
    push(1'b0, -1, -1);
`ifdef CLK_DIV_ODD_DUTY_EN
    push(1'b1, 5, 5); push(1'b0, 5, -1); push(1'b1, 5, 5);
`else
    push(1'b1, 6, 5); push(1'b0, 4, -1); push(1'b1, 6, 5);
`endif
    bus.div_in   = 8'd5;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    cyc(1);
    check("n5_div_cur", int'(bus.div_cur), 5);
    bus.en = 1'b1;
    cyc(7);
    bus.en = 1'b0;

    // N=8, en dropped at count 2, re-raised; then 10 loaded and reset at count 3.
    cyc(4);
    push(1'b0, -1, -1);
    push(1'b1, 8, 8);
    push(1'b0, -1, -1);
    push(1'b1, 8, 8); push(1'b0, 8, -1);
    push(1'b1, 8, 2);
    bus.div_in   = 8'd8;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    cyc(1);
    check("n8_div_cur", int'(bus.div_cur), 8);
    bus.en = 1'b1;
    cyc(3);
    bus.en = 1'b0;
    cyc(5);
    check("en_drop_last_low", int'(bus.clk_out), 0);
    cyc(1);
    check("en_drop_parked_clk", int'(bus.clk_out), 0);
    check("en_drop_parked_tick", int'(bus.tick),   0);
    cyc(2);
    check("en_drop_still_parked", int'(bus.clk_out), 0);
    bus.en = 1'b1;
    cyc(1);
    check("restart_clk_out", int'(bus.clk_out), 1);
    check("restart_tick",    int'(bus.tick),    1);
    bus.div_in   = 8'd10;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    check("n10_load_ready_low", int'(bus.div_ready), 0);
    check("n10_load_div_cur",   int'(bus.div_cur),   8);
    cyc(7);
    check("n10_div_cur", int'(bus.div_cur),   10);
    check("n10_ready",   int'(bus.div_ready), 1);
    cyc(3);
    rst    = 1'b1;
    bus.en = 1'b0;
    cyc(1);
    check("mid_rst_clk_out",   int'(bus.clk_out),   0);
    check("mid_rst_tick",      int'(bus.tick),      0);
    check("mid_rst_div_cur",   int'(bus.div_cur),   2);
    check("mid_rst_div_ready", int'(bus.div_ready), 1);
    rst = 1'b0;
    cyc(1);
    check("post_rst_idle", int'(bus.clk_out), 0);

    // Clamping of 0 and 1, and a load ignored while one is pending.
    bus.div_in   = 8'd7;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    cyc(1);
    check("load7_div_cur", int'(bus.div_cur), 7);
    bus.div_in   = 8'd0;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    cyc(1);
    check("clamp0_div_cur", int'(bus.div_cur), 2);
    bus.div_in   = 8'd9;
    bus.div_load = 1'b1;
    cyc(1);
    bus.div_load = 1'b0;
    cyc(1);
    check("load9_div_cur", int'(bus.div_cur), 9);
    bus.div_in   = 8'd1;
    bus.div_load = 1'b1;
    cyc(1);
    check("pending_ready_low", int'(bus.div_ready), 0);
    bus.div_in = 8'd13;
    cyc(1);
    check("clamp1_div_cur", int'(bus.div_cur), 2);
    bus.div_load = 1'b0;
    cyc(1);
    check("ignored_load_div_cur", int'(bus.div_cur),   2);
    check("ignored_load_ready",   int'(bus.div_ready), 1);

    // Short run at the clamped ratio.
    push(1'b0, -1, -1);
    push(1'b1, 2, 2); push(1'b0, 2, -1); push(1'b1, 2, 2);
    bus.en = 1'b1;
    cyc(3);
    bus.en = 1'b0;
    cyc(6);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
